// File: rtl/fmap_pkg.sv
// Shared definitions for the feature-map stream source.
// Optional zero-border padding is controlled by the FMAP_STREAM_PAD_EN macro.
package fmap_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAPW  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam int DEFAULT_K   = 3;
  localparam int DEFAULT_LEN = 9;

  // Border width and padded grid size for the default geometry.
  localparam int P       = (DEFAULT_K - 1) / 2;
  localparam int PAD_LEN = DEFAULT_LEN + 2 * P;

  function automatic int pad_of(input int k);
    return (k - 1) / 2;
  endfunction

  function automatic int padded_len(input int len, input int k);
    return len + 2 * pad_of(k);
  endfunction

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    while ((max_val >> w) != 0) w++;
    return w;
  endfunction

endpackage

// File: rtl/fmap_pos_cnt.sv
// Row/column raster counter over a DIM x DIM grid.
// Under FMAP_STREAM_PAD_EN it also flags positions in the PAD-wide border.
module fmap_pos_cnt
  import fmap_pkg::*;
#(
  parameter int DIM = PAD_LEN
`ifdef FMAP_STREAM_PAD_EN
  ,
  parameter int PAD = P
`endif
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic advance,
  output logic last
`ifdef FMAP_STREAM_PAD_EN
  ,
  output logic border
`endif
);

  localparam int W = cnt_width(DIM - 1);
  localparam logic [W-1:0] MAX_POS = W'(DIM - 1);

  logic [W-1:0] row_q, row_d;
  logic [W-1:0] col_q, col_d;

  // Step col every advance, wrapping into the next row at the right edge.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (advance) begin
      if (col_q == MAX_POS) begin
        col_d = '0;
        row_d = (row_q == MAX_POS) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign last = (row_q == MAX_POS) && (col_q == MAX_POS);

`ifdef FMAP_STREAM_PAD_EN
  localparam logic [W-1:0] LO = W'(PAD);
  localparam logic [W-1:0] HI = W'(DIM - 1 - PAD);
  assign border = (row_q < LO) || (row_q > HI) || (col_q < LO) || (col_q > HI);
`endif

endmodule

// File: rtl/fmap_stream_src.sv
// Feature-map source: streams one LEN x LEN frame from a synchronous buffer
// in raster order, one beat per pixel, GAP idle cycles between beats.
// Define FMAP_STREAM_PAD_EN to wrap the frame in a zero border of (K-1)/2.
module fmap_stream_src
  import fmap_pkg::*;
#(
  parameter int CH_NUM     = 6,
  parameter int DATA_WIDTH = 6,
  parameter int K          = DEFAULT_K,
  parameter int LEN        = DEFAULT_LEN,
  parameter int GAP        = 3,
  parameter int ADDR_WIDTH = $clog2(LEN * LEN)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         mem_ren,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic [CH_NUM*DATA_WIDTH-1:0] mem_rdata,
  output logic                         ovalid,
  output logic [CH_NUM*DATA_WIDTH-1:0] odata
);

  localparam int DW = CH_NUM * DATA_WIDTH;
`ifdef FMAP_STREAM_PAD_EN
  localparam int DIM = padded_len(LEN, K);
`else
  localparam int DIM = LEN;
`endif
  localparam int GW = cnt_width(GAP);
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(LEN * LEN - 1);

  state_e state_q, state_d;
  logic issue;
  logic pos_last;
  logic [GW-1:0] gap_q, gap_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic beat_q, beat_d;
  logic last_q, last_d;
  logic ovalid_q, ovalid_d;
  logic done_q, done_d;
  logic [DW-1:0] odata_q, odata_d;
`ifdef FMAP_STREAM_PAD_EN
  logic pos_border;
  logic pad_q, pad_d;
`endif

  fmap_pos_cnt #(
    .DIM(DIM)
`ifdef FMAP_STREAM_PAD_EN
    ,
    .PAD(pad_of(K))
`endif
  ) u_pos (
    .clk    (clk),
    .rstn   (rstn),
    .clear  (state_q == IDLE),
    .advance(issue),
    .last   (pos_last)
`ifdef FMAP_STREAM_PAD_EN
    ,
    .border (pos_border)
`endif
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: one ISSUE slot per position, GAP wait cycles in between.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = ISSUE;
      ISSUE: begin
        if (pos_last)     state_d = DRAIN;
        else if (GAP > 0) state_d = GAPW;
        else              state_d = ISSUE;
      end
      GAPW:  if (gap_q == '0) state_d = ISSUE;
      DRAIN: if (done_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: border slots in the padded grid never touch the buffer.
  always_comb begin
    issue = (state_q == ISSUE);
    busy  = (state_q != IDLE);
`ifdef FMAP_STREAM_PAD_EN
    mem_ren = issue && !pos_border;
`else
    mem_ren = issue;
`endif
  end

  // Gap/address counters and the two-stage beat pipeline matching read latency.
  always_comb begin
    gap_d = gap_q;
    if (issue) gap_d = GAP_LOAD;
    else if ((state_q == GAPW) && (gap_q != '0)) gap_d = gap_q - 1'b1;

    addr_d = addr_q;
    if (state_q == IDLE) addr_d = '0;
    else if (mem_ren && (addr_q != ADDR_MAX)) addr_d = addr_q + 1'b1;

    beat_d = issue;
    last_d = issue && pos_last;
`ifdef FMAP_STREAM_PAD_EN
    pad_d  = issue && pos_border;
`endif

    ovalid_d = beat_q;
    done_d   = beat_q && last_q;
    odata_d  = odata_q;
`ifdef FMAP_STREAM_PAD_EN
    if (beat_q) odata_d = pad_q ? '0 : mem_rdata;
`else
    if (beat_q) odata_d = mem_rdata;
`endif
  end

  // Datapath registers; reset discards any read still in flight.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      gap_q    <= '0;
      addr_q   <= '0;
      beat_q   <= 1'b0;
      last_q   <= 1'b0;
      ovalid_q <= 1'b0;
      done_q   <= 1'b0;
      odata_q  <= '0;
`ifdef FMAP_STREAM_PAD_EN
      pad_q    <= 1'b0;
`endif
    end else begin
      gap_q    <= gap_d;
      addr_q   <= addr_d;
      beat_q   <= beat_d;
      last_q   <= last_d;
      ovalid_q <= ovalid_d;
      done_q   <= done_d;
      odata_q  <= odata_d;
`ifdef FMAP_STREAM_PAD_EN
      pad_q    <= pad_d;
`endif
    end
  end

  assign mem_addr = addr_q;
  assign ovalid   = ovalid_q;
  assign odata    = odata_q;
  assign done     = done_q;

endmodule

// File: tb/tb_fmap_stream_src.sv
// Self-checking bench for fmap_stream_src: random buffer contents and random
// reset points, compared against a grid-level model of the expected stream.
module tb_fmap_stream_src;

  localparam int CH   = 6;
  localparam int DWID = 6;
  localparam int KK   = 3;
  localparam int LEN  = 9;
  localparam int GAP  = 3;
  localparam int AW   = $clog2(LEN * LEN);
  localparam int DW   = CH * DWID;
`ifdef FMAP_STREAM_PAD_EN
  localparam int P = (KK - 1) / 2;
`else
  localparam int P = 0;
`endif
  localparam int DIM = LEN + 2 * P;
  localparam int N   = DIM * DIM;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  logic busy, done, mem_ren, ovalid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] odata;

  logic [DW-1:0] mem [LEN*LEN];

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int c;
    logic [DW-1:0] d;
    logic dn;
  } beat_t;
  beat_t beats[$];
  int doneCount = 0;
  int renCount = 0;

  fmap_stream_src #(
    .CH_NUM(CH), .DATA_WIDTH(DWID), .K(KK), .LEN(LEN), .GAP(GAP), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done),
    .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .ovalid(ovalid), .odata(odata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous buffer; returns junk on cycles without a read.
  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= mem[mem_addr];
    else         mem_rdata <= DW'({$urandom(), $urandom()});
  end

  // Stream monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (ovalid) beats.push_back('{cyc, odata, done});
    if (done) doneCount++;
    if (mem_ren) renCount++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic r);
    @(posedge clk);
    #1;
    start = s;
    rstn  = r;
  endtask

  task automatic clearMonitor();
    beats.delete();
    doneCount = 0;
    renCount  = 0;
  endtask

  task automatic loadMem(input bit rnd);
    for (int i = 0; i < LEN * LEN; i++) begin
      if (rnd) mem[i] = DW'({$urandom(), $urandom()});
      else for (int ch = 0; ch < CH; ch++) mem[i][ch*DWID +: DWID] = DWID'(i + 1);
    end
  endtask

  // Beat k of the raster over the (possibly padded) grid.
  function automatic logic [DW-1:0] expBeat(input int k);
    int r, c;
    r = k / DIM;
    c = k % DIM;
    if (r < P || r >= P + LEN || c < P || c >= P + LEN) return '0;
    return mem[(r - P) * LEN + (c - P)];
  endfunction

  task automatic runFrame(input string tag, input bit hold);
    int t0, last, busyErr;
    applyStimulus(1'b1, 1'b1);
    t0 = cyc;
    clearMonitor();
    @(negedge clk);
    checkOutput({tag, ".busyAtStart"}, 64'(busy), 64'd0);
    if (!hold) applyStimulus(1'b0, 1'b1);
    else begin
      @(posedge clk);
      #1;
    end
    last = t0 + 3 + (N - 1) * (GAP + 1);
    busyErr = 0;
    for (int c = t0 + 1; c <= last; c++) begin
      @(negedge clk);
      if (busy !== 1'b1) busyErr++;
      if (c < last) begin
        @(posedge clk);
        #1;
      end
    end
    #1;
    checkOutput({tag, ".busyHigh"}, 64'(busyErr), 64'd0);
    checkOutput({tag, ".beatCount"}, 64'(beats.size()), 64'(N));
    checkOutput({tag, ".doneCount"}, 64'(doneCount), 64'd1);
    checkOutput({tag, ".renCount"}, 64'(renCount), 64'(LEN * LEN));
    for (int k = 0; k < beats.size() && k < N; k++) begin
      checkOutput($sformatf("%s.cyc[%0d]", tag, k), 64'(beats[k].c - t0), 64'(3 + k * (GAP + 1)));
      checkOutput($sformatf("%s.data[%0d]", tag, k), 64'(beats[k].d), 64'(expBeat(k)));
      checkOutput($sformatf("%s.done[%0d]", tag, k), 64'(beats[k].dn), 64'(k == N - 1));
    end
  endtask

  task automatic waitIdle(input string tag, input int n);
    int err;
    err = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      if (busy !== 1'b0 || ovalid !== 1'b0 || done !== 1'b0 || mem_ren !== 1'b0) err++;
    end
    checkOutput({tag, ".idle"}, 64'(err), 64'd0);
  endtask

  task automatic runReset(input string tag, input int beatIdx);
    int t0, target;
    applyStimulus(1'b1, 1'b1);
    t0 = cyc;
    clearMonitor();
    applyStimulus(1'b0, 1'b1);
    target = t0 + 3 + beatIdx * (GAP + 1);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    checkOutput({tag, ".ovalid"}, 64'(ovalid), 64'd0);
    checkOutput({tag, ".odata"}, 64'(odata), 64'd0);
    checkOutput({tag, ".done"}, 64'(done), 64'd0);
    checkOutput({tag, ".busy"}, 64'(busy), 64'd0);
    checkOutput({tag, ".memRen"}, 64'(mem_ren), 64'd0);
    checkOutput({tag, ".memAddr"}, 64'(mem_addr), 64'd0);
    #1;
    checkOutput({tag, ".beatsBefore"}, 64'(beats.size()), 64'(beatIdx + 1));
    if (beats.size() > 0)
      checkOutput({tag, ".lastBeatData"}, 64'(beats[beats.size()-1].d), 64'(expBeat(beats.size() - 1)));
    waitIdle({tag, ".after"}, 15);
  endtask

  initial begin
    $display("[TB] start: LEN=%0d GAP=%0d grid=%0d beats=%0d", LEN, GAP, DIM, N);
    rstn  = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst.busy", 64'(busy), 64'd0);
    checkOutput("rst.done", 64'(done), 64'd0);
    checkOutput("rst.memRen", 64'(mem_ren), 64'd0);
    checkOutput("rst.memAddr", 64'(mem_addr), 64'd0);
    checkOutput("rst.ovalid", 64'(ovalid), 64'd0);
    checkOutput("rst.odata", 64'(odata), 64'd0);
    applyStimulus(1'b0, 1'b1);
    waitIdle("postRst", 3);

    loadMem(1'b0);
    runFrame("ramp", 1'b0);
    waitIdle("rampTail", 5);

    loadMem(1'b1);
    runFrame("hold", 1'b1);
    waitIdle("holdTail", 10);

    loadMem(1'b1);
    runFrame("b2bA", 1'b0);
    runFrame("b2bB", 1'b0);
    waitIdle("b2bTail", 4);

    loadMem(1'b0);
    runReset("rst40", 39);
    loadMem(1'b1);
    runFrame("afterRst", 1'b0);
    waitIdle("afterRstTail", 3);

    for (int it = 0; it < 3; it++) begin
      loadMem(1'b1);
      runReset($sformatf("rndRst%0d", it), int'($urandom_range(0, N - 2)));
      runFrame($sformatf("rndFrame%0d", it), 1'b0);
      waitIdle($sformatf("rndTail%0d", it), int'($urandom_range(1, 4)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fmap_stream_src.md
# fmap_stream_src

Feature-map source that feeds the binary-conv sliding-window generator (`conv_slide`). On a `start` pulse, it reads one LEN×LEN feature map from a synchronous on-chip buffer in raster order and emits one pixel beat (all CH_NUM channels) per pixel. Each beat is `ovalid` with `odata`, spaced by a programmable idle gap, and the block raises `done` on the final beat. It sits between the activation buffer and `conv_slide`, and is the transmitting end of the `ivalid`/`idata` stream that `conv_slide` consumes.

## Interface
- CH_NUM, 6, channels per pixel
- DATA_WIDTH, 6, bits per channel
- K, 3, downstream kernel size (odd); used only for padding
- LEN, 9, feature-map width = height
- GAP, 3, idle cycles between consecutive beats (0 = back-to-back)
- ADDR_WIDTH, $clog2(LEN*LEN), buffer address width

- clk  in  1  clock, all logic on rising edge
- rstn  in  1  synchronous, active-low reset
- start  in  1  one-cycle request to stream one frame; ignored while busy
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse, coincident with last ovalid
- mem_ren  out  1  buffer read enable
- mem_addr  out  ADDR_WIDTH  buffer read address (row*LEN+col)
- mem_rdata  in  CH_NUM*DATA_WIDTH  read data, valid exactly 1 cycle after mem_ren
- ovalid  out  1  pixel beat valid (maps to conv_slide ivalid)
- odata  out  CH_NUM*DATA_WIDTH  pixel beat, channel 0 in LSBs (maps to idata)

## Operation
- FSM states: IDLE, ISSUE, GAPW, DRAIN.
  - IDLE: `start` -> ISSUE. Row/col/address counters are cleared.
  - ISSUE (1 cycle): issues a read for the current position, then advances col. At col wrap, col returns to 0 and row increments. If the position was the last one -> DRAIN. Otherwise -> GAPW if GAP>0, else stay in ISSUE.
  - GAPW: waits GAP cycles, then -> ISSUE.
  - DRAIN: waits for the final beat to be emitted, then -> IDLE.
- Address increments by 1 per interior read and never exceeds LEN*LEN-1.
- Output path:
  - `ren_d` is `mem_ren` delayed by 1 cycle.
  - Registers are loaded from `mem_rdata` while `ren_d` is high: `odata <= mem_rdata`, `ovalid <= 1`.
  - Otherwise `ovalid <= 0` and `odata` holds its value.
- Beat count per frame = LEN*LEN (padding off). No backpressure: the downstream block always accepts.
- `start` is sampled only in IDLE. A `start` in the same cycle as `done` is ignored, because the FSM is still in DRAIN.
- Reset mid-frame: the next cycle is IDLE. All counters return to 0, every output is 0, and no further beat is emitted. A read already in flight is discarded.
- Reset values: busy=0, done=0, mem_ren=0, mem_addr=0, ovalid=0, odata=0.

## Timing
- `start` at cycle T -> first `mem_ren` at T+1 (addr 0) -> first `ovalid` at T+3.
- Beat period = GAP+1 cycles. With GAP=3, beats land every 4 cycles.
- `busy` is high from T+1 through the `done` cycle inclusive.
- Last beat, which coincides with `done`, arrives at T+3+(N-1)(GAP+1), where N = beat count.
- Back-to-back frames: the earliest accepted next `start` is the cycle after `done`.

## Configuration
- FMAP_STREAM_PAD_EN defined:
  - The block emits a zero border of P=(K-1)/2 pixels on all sides, so it streams (LEN+2P)² beats in raster order over the padded grid.
  - Border positions issue no `mem_ren`. Their beat still appears 2 cycles after the ISSUE slot with `odata`=0 and `ovalid`=1.
  - Interior positions read address (row-P)*LEN+(col-P).
- FMAP_STREAM_PAD_EN undefined: the block streams LEN² beats with no padding logic.

## Structure
- Shared package `fmap_pkg`:
  - state enum (IDLE/ISSUE/GAPW/DRAIN)
  - P = (K-1)/2
  - padded-dimension constant LEN+2P
  - count-width constants
- One sub-module, `fmap_pos_cnt`: a row/col raster counter with wrap, last-position flag, and (under the macro) a border flag. The top level holds the FSM, gap counter, address counter, and output register.

## Test plan
- Buffer preloaded with pixel i = {6{i+1}}, LEN=9, GAP=3, start at T -> 81 beats at T+3, T+7, …, T+323 carrying values 1..81. `done` pulses only at T+323, and `busy` drops at T+324.
- GAP=0 -> 81 consecutive `ovalid` cycles with `mem_ren` high for 81 cycles, then `done` coincident with value 81.
- `start` held high for the whole frame and re-pulsed on the `done` cycle -> exactly one frame. A new pulse at done+1 starts the second frame with first `ovalid` 3 cycles later.
- `rstn` low for 1 cycle during beat 40 -> every output is 0 the next cycle, there are no further beats, and a following start streams a full fresh 81-beat frame from address 0.
- FMAP_STREAM_PAD_EN, K=3 -> 121 beats. Beats 1–12 are 0, beat 13 is value 1, and beat 121 is 0. `mem_ren` count is exactly 81.
- Downstream check: chain into `conv_slide` (LEN=9, K=3) -> the first window's 9 taps equal {1,2,3,10,11,12,19,20,21} on every channel.
